// File: rtl/uart_pkg.sv
// Shared definitions for the serial frame checker: parity modes, receiver
// states and a frame length helper.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_BREAK,
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    // Total line samples in one frame, start bit through last stop bit.
    function automatic int frame_len(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_break_detect.sv
// Counts consecutive low line samples and flags a break once the run
// reaches BREAK_LEN; any high sample clears it.
module uart_break_detect #(
    parameter int BREAK_LEN = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic signal,
    output logic break_det
);

    localparam int CW = $clog2(BREAK_LEN + 1);
    localparam logic [CW-1:0] RUN_MAX = CW'(BREAK_LEN);

    logic [CW-1:0] count_q, count_d;

    // Saturate so a long break never wraps back below the threshold.
    always_comb begin
        count_d = count_q;
        if (signal) begin
            count_d = '0;
        end else if (count_q != RUN_MAX) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign break_det = (count_q == RUN_MAX);

endmodule

// File: rtl/uart_frame_checker.sv
// Serial frame receiver: recovers the data word of each frame and reports
// good frames, parity errors, framing errors and line breaks.
module uart_frame_checker
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 2,
    parameter int STOP_BITS = 1,
    parameter int BREAK_LEN = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 signal,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);
    localparam logic HAS_PARITY = (PARITY != PARITY_NONE);
    localparam logic ODD_PARITY = (PARITY == PARITY_ODD);

    if (PARITY != PARITY_NONE && PARITY != PARITY_EVEN && PARITY != PARITY_ODD) begin : g_bad_parity
        $error("uart_frame_checker: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_frame_checker: STOP_BITS must be 1 or 2");
    end
    if (DATA_BITS < 1 || DATA_BITS > 16) begin : g_bad_data
        $error("uart_frame_checker: DATA_BITS must be 1..16");
    end
    if (BREAK_LEN <= DATA_BITS + 2) begin : g_bad_break
        $error("uart_frame_checker: BREAK_LEN must exceed DATA_BITS+2");
    end

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 acc_q, acc_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 parity_ok;

    assign parity_ok = !HAS_PARITY || (acc_q == ODD_PARITY);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_BREAK;
            cnt_q   <= '0;
            shift_q <= '0;
            acc_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    // A low stop sample means the line may be in a break, so wait for high.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_BREAK:  if (signal) state_d = ST_IDLE;
            ST_IDLE:   if (!signal) state_d = ST_DATA;
            ST_DATA:   if (cnt_q == LAST_DATA) state_d = HAS_PARITY ? ST_PARITY : ST_STOP;
            ST_PARITY: state_d = ST_STOP;
            ST_STOP: begin
                if (!signal) begin
                    state_d = ST_BREAK;
                end else if (cnt_q == LAST_STOP) begin
                    state_d = ST_IDLE;
                end
            end
            default:   state_d = ST_BREAK;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        data_d  = data_q;
        valid_d = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!signal) begin
                    shift_d = '0;
                    acc_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            ST_DATA: begin
                // LSB arrives first, so new bits enter at the top and drift down.
                shift_d = (shift_q >> 1) | (DATA_BITS'(signal) << (DATA_BITS - 1));
                acc_d   = acc_q ^ signal;
                cnt_d   = (cnt_q == LAST_DATA) ? '0 : cnt_q + 1'b1;
            end
            ST_PARITY: acc_d = acc_q ^ signal;
            ST_STOP: begin
                if (!signal) begin
                    ferr_d = 1'b1;
                    cnt_d  = '0;
                end else if (cnt_q == LAST_STOP) begin
                    data_d  = shift_q;
                    valid_d = parity_ok;
                    perr_d  = !parity_ok;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;

    uart_break_detect #(
        .BREAK_LEN(BREAK_LEN)
    ) u_break (
        .clk      (clk),
        .reset    (reset),
        .signal   (signal),
        .break_det(break_det)
    );

endmodule

// File: tb/tb_uart_frame_checker.sv
// Self-checking bench: two checker configurations driven with directed frames,
// compared every cycle against a frame-level scoreboard and a low-run model.
module tb_uart_frame_checker;
    import uart_pkg::*;

    localparam int KEY = 1000000;
    localparam int BRK = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       sig_a, sig_b;
    logic [7:0] data_a;
    logic [4:0] data_b;
    logic       valid_a, perr_a, ferr_a, break_a;
    logic       valid_b, perr_b, ferr_b, break_b;

    int tests = 0;
    int fails = 0;
    int edge_cnt = 0;
    int low_run [2] = '{0, 0};
    bit rst_seen = 1'b0;
    logic [15:0] mdata [2] = '{16'h0, 16'h0};

    bit          ev_valid [int];
    bit          ev_perr  [int];
    bit          ev_ferr  [int];
    logic [15:0] ev_data  [int];

    always #5 clk = ~clk;

    uart_frame_checker u_dut_a (
        .clk(clk), .reset(reset), .signal(sig_a), .data(data_a),
        .valid(valid_a), .parity_err(perr_a), .frame_err(ferr_a), .break_det(break_a)
    );

    uart_frame_checker #(
        .DATA_BITS(5), .PARITY(0), .STOP_BITS(2), .BREAK_LEN(BRK)
    ) u_dut_b (
        .clk(clk), .reset(reset), .signal(sig_b), .data(data_b),
        .valid(valid_b), .parity_err(perr_b), .frame_err(ferr_b), .break_det(break_b)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Line model: runs of low samples, reset clears everything.
    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        rst_seen = reset;
        if (!reset) begin
            low_run[0] = 0;
            low_run[1] = 0;
        end else begin
            low_run[0] = sig_a ? 0 : low_run[0] + 1;
            low_run[1] = sig_b ? 0 : low_run[1] + 1;
        end
    end

    always @(negedge clk) begin : compare
        int k, key;
        bit ev_v, ev_p, ev_f;
        logic av, ap, af, ab;
        logic [15:0] ad;
        string nm;
        k = edge_cnt - 1;
        if (k >= 0) begin
            for (int inst = 0; inst < 2; inst++) begin
                key  = inst * KEY + k;
                ev_v = rst_seen && ev_valid.exists(key);
                ev_p = rst_seen && ev_perr.exists(key);
                ev_f = rst_seen && ev_ferr.exists(key);
                if (!rst_seen) mdata[inst] = 16'h0;
                else if (ev_v || ev_p) mdata[inst] = ev_data[key];
                if (inst == 0) begin
                    nm = "A"; av = valid_a; ap = perr_a; af = ferr_a; ab = break_a; ad = {8'h0, data_a};
                end else begin
                    nm = "B"; av = valid_b; ap = perr_b; af = ferr_b; ab = break_b; ad = {11'h0, data_b};
                end
                checkOutput($sformatf("valid %s", nm), {31'b0, av}, {31'b0, ev_v});
                checkOutput($sformatf("parity_err %s", nm), {31'b0, ap}, {31'b0, ev_p});
                checkOutput($sformatf("frame_err %s", nm), {31'b0, af}, {31'b0, ev_f});
                checkOutput($sformatf("data %s", nm), {16'b0, ad}, {16'b0, mdata[inst]});
                checkOutput($sformatf("break_det %s", nm), {31'b0, ab}, {31'b0, (low_run[inst] >= BRK)});
            end
        end
    end

    // Drive one line sample; e is the index of the edge that will sample it.
    task automatic sendBit(input int inst, input bit b, output int e);
        @(negedge clk);
        e = edge_cnt;
        if (inst == 0) sig_a = b;
        else sig_b = b;
    endtask

    task automatic applyStimulus(input int inst, input logic [15:0] value, input int nbits,
                                 input int pmode, input bit flip, input int nstop, input int bad_stop);
        int e;
        bit p;
        sendBit(inst, 1'b0, e);
        p = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            sendBit(inst, value[i], e);
            p = p ^ value[i];
        end
        if (pmode != PARITY_NONE) begin
            p = p ^ (pmode == PARITY_ODD) ^ flip;
            sendBit(inst, p, e);
        end
        for (int s = 0; s < nstop; s++) begin
            if (s == bad_stop) begin
                sendBit(inst, 1'b0, e);
                ev_ferr[inst * KEY + e] = 1'b1;
                return;
            end
            sendBit(inst, 1'b1, e);
        end
        if (flip) ev_perr[inst * KEY + e] = 1'b1;
        else ev_valid[inst * KEY + e] = 1'b1;
        ev_data[inst * KEY + e] = value;
    endtask

    task automatic idle(input int n);
        int e;
        for (int i = 0; i < n; i++) sendBit(0, 1'b1, e);
    endtask

    initial begin : stim
        int e, e0;
        reset = 1'b0;
        sig_a = 1'b1;
        sig_b = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset data", {24'b0, data_a}, 32'h0);
        checkOutput("reset valid", {31'b0, valid_a}, 32'h0);
        checkOutput("reset parity_err", {31'b0, perr_a}, 32'h0);
        checkOutput("reset frame_err", {31'b0, ferr_a}, 32'h0);
        checkOutput("reset break_det", {31'b0, break_a}, 32'h0);
        reset = 1'b1;
        idle(3);

        // 0xA5 with correct odd parity
        applyStimulus(0, 16'h00A5, 8, PARITY_ODD, 1'b0, 1, -1);
        sendBit(0, 1'b1, e);
        checkOutput("A5 valid", {31'b0, valid_a}, 32'h1);
        checkOutput("A5 data", {24'b0, data_a}, 32'hA5);
        sendBit(0, 1'b1, e);
        checkOutput("A5 valid width", {31'b0, valid_a}, 32'h0);
        idle(2);

        // same frame, parity bit flipped
        applyStimulus(0, 16'h00A5, 8, PARITY_ODD, 1'b1, 1, -1);
        sendBit(0, 1'b1, e);
        checkOutput("A5 perr", {31'b0, perr_a}, 32'h1);
        checkOutput("A5 perr valid", {31'b0, valid_a}, 32'h0);
        checkOutput("A5 perr data", {24'b0, data_a}, 32'hA5);
        idle(2);

        // 0x3C with low stop bit, then a start bit that must be ignored
        applyStimulus(0, 16'h003C, 8, PARITY_ODD, 1'b0, 1, 0);
        sendBit(0, 1'b0, e);
        checkOutput("3C frame_err", {31'b0, ferr_a}, 32'h1);
        checkOutput("3C data held", {24'b0, data_a}, 32'hA5);
        for (int i = 0; i < 3; i++) sendBit(0, 1'b0, e);
        idle(12);

        // back-to-back frames with no idle gap
        applyStimulus(0, 16'h0001, 8, PARITY_ODD, 1'b0, 1, -1);
        applyStimulus(0, 16'h00FF, 8, PARITY_ODD, 1'b0, 1, -1);
        sendBit(0, 1'b1, e);
        checkOutput("b2b second valid", {31'b0, valid_a}, 32'h1);
        checkOutput("b2b second data", {24'b0, data_a}, 32'hFF);
        idle(2);

        // 5-bit, no parity, two stop bits
        applyStimulus(1, 16'h000B, 5, PARITY_NONE, 1'b0, 2, -1);
        sendBit(1, 1'b1, e);
        checkOutput("B 0B valid", {31'b0, valid_b}, 32'h1);
        checkOutput("B 0B data", {27'b0, data_b}, 32'h0B);
        applyStimulus(1, 16'h0015, 5, PARITY_NONE, 1'b0, 2, 1);
        sendBit(1, 1'b1, e);
        checkOutput("B second stop frame_err", {31'b0, ferr_b}, 32'h1);
        checkOutput("B second stop valid", {31'b0, valid_b}, 32'h0);
        checkOutput("B data held", {27'b0, data_b}, 32'h0B);
        sendBit(1, 1'b1, e);
        idle(2);

        // break: 40 low samples from idle
        for (int i = 0; i < 40; i++) begin
            sendBit(0, 1'b0, e);
            if (i == 0) begin
                e0 = e;
                ev_ferr[e0 + frame_len(8, PARITY_ODD, 1) - 1] = 1'b1;
            end
            if (i == 31) checkOutput("break after 31 lows", {31'b0, break_a}, 32'h0);
            if (i == 32) checkOutput("break after 32 lows", {31'b0, break_a}, 32'h1);
        end
        sendBit(0, 1'b1, e);
        checkOutput("break held at 40 lows", {31'b0, break_a}, 32'h1);
        sendBit(0, 1'b1, e);
        checkOutput("break cleared by high", {31'b0, break_a}, 32'h0);
        idle(2);

        // reset mid-frame: nothing reported, and state must wait for a high line
        sendBit(0, 1'b0, e);
        sendBit(0, 1'b1, e);
        sendBit(0, 1'b0, e);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checkOutput("midreset data", {24'b0, data_a}, 32'h0);
        checkOutput("midreset valid", {31'b0, valid_a}, 32'h0);
        checkOutput("midreset frame_err", {31'b0, ferr_a}, 32'h0);
        checkOutput("midreset break_det", {31'b0, break_a}, 32'h0);
        for (int i = 0; i < 8; i++) sendBit(0, 1'b0, e);
        idle(3);
        applyStimulus(0, 16'h005A, 8, PARITY_ODD, 1'b0, 1, -1);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
